cache_plru_engine: RTL
======================

Name: cache_plru_engine

Overview:
- Stateful tree-PLRU replacement engine for an N-way set-associative cache.
- Owns the PLRU bit array for all sets. Accepts one lookup per cycle: hit updates toward the hit way, miss selects and updates toward a victim.
- Sits beside the tag array and cache controller, taking over from the per-access combinational PLRU get/update path.
- Adds on-chip storage, a 2-stage pipeline with same-set forwarding, and a clear/flush sequencer.

Parameters:
- WAYS, 8, associativity; power of two, 2..64.
- WAYS_REP, $clog2(WAYS), width of way index.
- SETS, 64, number of sets; power of two.
- SET_W, $clog2(SETS), width of set index.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  one-cycle pulse; clears all PLRU state.
- req_valid  input  1  lookup request present.
- req_ready  output  1  engine accepts a request this cycle.
- req_set  input  SET_W  set index.
- req_hit  input  1  1 = hit on req_way; 0 = miss, victim wanted.
- req_way  input  WAYS_REP  hit way; ignored when req_hit=0.
- req_valid_mask  input  WAYS  per-way valid bits of the set; used only with the optional feature.
- resp_valid  output  1  response valid; one-cycle pulse.
- resp_way  output  WAYS_REP  hit way echoed, or chosen victim.
- resp_set  output  SET_W  set of the response.
- busy  output  1  clear sequence in progress.

Behaviour:
- **Tree encoding**
  - Per-set vector of WAYS-1 bits; bit k = node k; children of k are 2k+1 and 2k+2.
  - Victim walk starts at node 0: bit 0 → go left (lower ways), bit 1 → go right.
  - Update for way w: every node on w's path is set to point away from w. Off-path bits are unchanged.
- **FSM states**
  - CLEAR: a SET_W counter writes all-zero to set 0..SETS-1, one set per cycle. req_ready=0, busy=1. Goes to RUN after writing set SETS-1.
  - RUN: req_ready=1, busy=0.
  - rst → CLEAR with counter 0. flush in RUN → CLEAR with counter 0. flush in CLEAR restarts the counter at 0.
  - rst at any point, including mid-CLEAR or mid-pipeline, restarts CLEAR and discards in-flight requests.
- **Reset values**
  - resp_valid=0, resp_way=0, resp_set=0, req_ready=0, busy=1.
- **Pipeline**
  - A request is accepted when req_valid && req_ready.
  - S1 (accept cycle): array read of req_set; inputs registered.
  - S2 (next cycle): victim computed; resp_valid=1 with resp_way/resp_set; updated bits written to array at end of cycle.
  - Latency 1 cycle accept→resp_valid. Throughput 1 request/cycle. Response has no backpressure.
  - Hit: resp_way = req_way; update uses req_way.
  - Miss: resp_way = tree victim; update uses the victim.
- **Hazards and flush interaction**
  - Back-to-back requests to the same set: S1 uses the S2 write data (forwarding), never stale array data. Result must equal sequential processing.
  - A request accepted in the same cycle as flush is dropped (no resp).
  - A request in S2 when flush arrives completes its response, but its write is superseded by CLEAR.
- **Width and index rules**
  - Way index arithmetic is modulo WAYS_REP bits.
  - Out-of-range req_set cannot occur (power-of-two SETS).

Optional Feature:
- Macro: PLRU_INVALID_FIRST_EN.
- Defined: on a miss, if req_valid_mask != all-ones, victim = lowest-index way with mask bit 0. The tree walk is bypassed, but the tree is still updated toward that way. Hits are unaffected.
- Undefined: req_valid_mask is ignored; victim always comes from the tree walk.

Test Plan:
- Reset/clear: assert rst 1 cycle, SETS=64 → busy=1 and req_ready=0 for 64 cycles, then req_ready=1. A miss to set 5 then returns resp_way=0.
- Hit update, WAYS=8: hit way 0 on set 3 (bits 0, 1, 3 become 1), then miss on set 3 → resp_way=4. Another miss on set 3 → resp_way=2.
- Forwarding: back-to-back misses to set 7 on consecutive cycles with no idle → resp_way 0, then 4, then 2, then 6. Results must match the same sequence issued with idle gaps.
- Mid-operation flush: warm set 9 with hits on ways 0..7, pulse flush → 64-cycle CLEAR. A miss to set 9 then returns way 0; a request issued in the flush cycle gets no resp.
- Reset mid-CLEAR: rst at counter=30 → CLEAR restarts at 0, full 64 cycles of busy.
- With PLRU_INVALID_FIRST_EN: miss to set 2 with req_valid_mask=8'b1111_0111 → resp_way=3. A following miss with mask all-ones uses the tree updated toward way 3. Without the macro, the same stimulus gives resp_way=0.

Source files
------------

// File: rtl/cache_plru_engine.sv
// Tree-PLRU replacement engine: per-set PLRU storage, 2-stage lookup pipeline with
// same-set forwarding, and a clear/flush sequencer. Optional macro PLRU_INVALID_FIRST_EN.
module cache_plru_engine #(
    parameter int WAYS     = 8,
    parameter int WAYS_REP = $clog2(WAYS),
    parameter int SETS     = 64,
    parameter int SET_W    = $clog2(SETS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SET_W-1:0]    req_set,
    input  logic                req_hit,
    input  logic [WAYS_REP-1:0] req_way,
    input  logic [WAYS-1:0]     req_valid_mask,
    output logic                resp_valid,
    output logic [WAYS_REP-1:0] resp_way,
    output logic [SET_W-1:0]    resp_set,
    output logic                busy
);

    localparam int NODES = WAYS - 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]          state_reg, state_next;
    logic [SET_W-1:0]    clr_cnt_reg, clr_cnt_next;

    logic                s2_valid_reg;
    logic [SET_W-1:0]    s2_set_reg;
    logic                s2_hit_reg;
    logic [WAYS_REP-1:0] s2_way_reg;

    logic                fwd_reg;
    logic [NODES-1:0]    fwd_bits_reg;
    logic [NODES-1:0]    rd_bits_reg;

    logic [NODES-1:0]    plru_mem [SETS];

    logic                run;
    logic                accept;
    logic [NODES-1:0]    cur_bits;
    logic [NODES-1:0]    upd_bits;
    logic [WAYS-1:0]     victim_oh;
    logic [WAYS_REP-1:0] tree_way;
    logic [WAYS_REP-1:0] miss_way;
    logic [WAYS_REP-1:0] upd_way;

    logic                mem_we;
    logic [SET_W-1:0]    mem_waddr;
    logic [NODES-1:0]    mem_wdata;

    assign run       = (state_reg == ST_RUN);
    assign req_ready = run;
    assign busy      = !run;
    // A request coinciding with flush is dropped; the clear would erase its effect anyway.
    assign accept    = req_valid && run && !flush;

    // ------------------------------------------------------------------
    // Clear / run sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (flush) begin
            state_next   = ST_CLEAR;
            clr_cnt_next = '0;
        end else if (!run) begin
            if (clr_cnt_reg == SET_W'(SETS - 1)) begin
                state_next   = ST_RUN;
                clr_cnt_next = '0;
            end else begin
                clr_cnt_next = clr_cnt_reg + SET_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_CLEAR;
            clr_cnt_reg  <= '0;
            s2_valid_reg <= 1'b0;
            s2_set_reg   <= '0;
            s2_hit_reg   <= 1'b0;
            s2_way_reg   <= '0;
            fwd_reg      <= 1'b0;
            fwd_bits_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_cnt_reg  <= clr_cnt_next;
            s2_valid_reg <= accept;
            if (accept) begin
                s2_set_reg <= req_set;
                s2_hit_reg <= req_hit;
                s2_way_reg <= req_way;
            end
            // The array read in S1 cannot see the S2 write landing on the same edge.
            fwd_reg      <= accept && s2_valid_reg && (s2_set_reg == req_set);
            fwd_bits_reg <= upd_bits;
        end
    end

    // ------------------------------------------------------------------
    // PLRU storage: one write port (clear or S2 update), registered read
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_reg;
        mem_wdata = '0;
        if (run) begin
            mem_we    = s2_valid_reg && !flush;
            mem_waddr = s2_set_reg;
            mem_wdata = upd_bits;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            plru_mem[mem_waddr] <= mem_wdata;
        end
        rd_bits_reg <= plru_mem[req_set];
    end

    assign cur_bits = fwd_reg ? fwd_bits_reg : rd_bits_reg;

    // ------------------------------------------------------------------
    // Victim walk: a way is the victim when every node on its path points at it
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [WAYS_REP-1:0] agree;
        for (genvar gl = 0; gl < WAYS_REP; gl++) begin : g_lvl
            localparam int   ND  = (1 << gl) - 1 + (gi >> (WAYS_REP - gl));
            localparam logic DIR = 1'((gi >> (WAYS_REP - 1 - gl)) & 1);
            assign agree[gl] = (cur_bits[ND] == DIR);
        end
        assign victim_oh[gi] = &agree;
    end

    always_comb begin
        tree_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (victim_oh[i]) begin
                tree_way = tree_way | WAYS_REP'(i);
            end
        end
    end

`ifdef PLRU_INVALID_FIRST_EN
    logic [WAYS-1:0] s2_mask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_mask_reg <= '1;
        end else if (accept) begin
            s2_mask_reg <= req_valid_mask;
        end
    end

    // Lowest-index invalid way wins over the tree when any way is empty.
    always_comb begin
        miss_way = tree_way;
        if (!(&s2_mask_reg)) begin
            for (int i = WAYS - 1; i >= 0; i--) begin
                if (!s2_mask_reg[i]) begin
                    miss_way = WAYS_REP'(i);
                end
            end
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^req_valid_mask;
    assign miss_way    = tree_way;
`endif

    assign upd_way = s2_hit_reg ? s2_way_reg : miss_way;

    // ------------------------------------------------------------------
    // Update: nodes on the path of upd_way point away from it
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NODES; gi++) begin : g_node
        localparam int LVL = $clog2(gi + 2) - 1;
        localparam int OFF = (1 << LVL) - 1;
        logic on_path;
        assign on_path      = (int'(upd_way >> (WAYS_REP - LVL)) == (gi - OFF));
        assign upd_bits[gi] = on_path ? ~upd_way[WAYS_REP - 1 - LVL] : cur_bits[gi];
    end

    assign resp_valid = s2_valid_reg;
    assign resp_way   = s2_valid_reg ? upd_way : '0;
    assign resp_set   = s2_valid_reg ? s2_set_reg : '0;

endmodule
